// File: rtl/sprite_blit_writer_pkg.sv
// Shared frame-manager geometry, colour and source-select widths plus writer FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sprite_blit_writer_pkg;

    localparam int DRAW_WIDTH        = 640;
    localparam int DRAW_HEIGHT       = 480;
    localparam int DRAW_WIDTH_ADDRW  = $clog2(DRAW_WIDTH);
    localparam int DRAW_HEIGHT_ADDRW = $clog2(DRAW_HEIGHT);
    localparam int COLOR_DEPTH       = 8;
    localparam int SOURCE_SEL_ADDRW  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RELEASE = 2'd3
    } writer_state_t;

endpackage

// File: rtl/sprite_blit_writer_if.sv
// Write-client bus between a pixel writer and the double-buffered frame manager.
// Latency: n/a (wiring only).
// Backpressure: none; the manager gates the stream via write_awaited/write_source_sel.
interface sprite_blit_writer_if;
    import sprite_blit_writer_pkg::*;

    logic                          write_awaited;
    logic [SOURCE_SEL_ADDRW-1:0]   write_source_sel;
    logic                          write_active;
    logic                          write_transparent;
    logic [COLOR_DEPTH-1:0]        write_color_data;
    logic [DRAW_WIDTH_ADDRW-1:0]   write_x_addr;
    logic [DRAW_HEIGHT_ADDRW-1:0]  write_y_addr;

    modport master (
        input  write_awaited, write_source_sel,
        output write_active, write_transparent, write_color_data,
               write_x_addr, write_y_addr
    );

    modport slave (
        output write_awaited, write_source_sel,
        input  write_active, write_transparent, write_color_data,
               write_x_addr, write_y_addr
    );
endinterface

// File: rtl/sprite_blit_writer_sweep.sv
// Row-major cx/cy sweep over the sprite rectangle with a last-pixel flag.
// Latency: counters move on the edge after advance is seen; clear wins over advance.
// Backpressure: none; the caller simply withholds advance.
module sprite_sweep_counter #(
    parameter int SPR_W = 16,
    parameter int SPR_H = 16,
    parameter int CXW   = (SPR_W > 1) ? $clog2(SPR_W) : 1,
    parameter int CYW   = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    output logic [CXW-1:0] cx,
    output logic [CYW-1:0] cy,
    output logic           last
);

    logic cx_wrap;
    logic cy_wrap;

    assign cx_wrap = (cx == CXW'(SPR_W - 1));
    assign cy_wrap = (cy == CYW'(SPR_H - 1));
    assign last    = cx_wrap && cy_wrap;

    // Step cx every advance; on cx wrap restart the row and move to the next one.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cx <= '0;
            cy <= '0;
        end else if (advance) begin
            if (cx_wrap) begin
                cx <= '0;
                cy <= cy_wrap ? '0 : cy + CYW'(1);
            end else begin
                cx <= cx + CXW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blit_writer.sv
// Streams one SPR_W x SPR_H sprite from a 1-cycle ROM into the back buffer; optional SPRITE_BLIT_MIRROR_EN adds mirror_x.
// Latency: pixel (0,0) on outputs 3 edges after accept; SPR_W*SPR_H back-to-back pixels, then 2 drain cycles.
// Backpressure: none once accepted; a new sweep is only accepted after the manager drops write_awaited or reselects.
module sprite_blit_writer
    import sprite_blit_writer_pkg::*;
#(
    parameter int                     SOURCE_ID = 0,
    parameter int                     SPR_W     = 16,
    parameter int                     SPR_H     = 16,
    parameter logic [COLOR_DEPTH-1:0] KEY_COLOR = 8'hE3,
    localparam int AW  = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    sprite_blit_writer_if.master          wr,
    input  logic                          sprite_en,
    input  logic [DRAW_WIDTH_ADDRW-1:0]   pos_x,
    input  logic [DRAW_HEIGHT_ADDRW-1:0]  pos_y,
    output logic [AW-1:0]                 rom_addr,
    input  logic [COLOR_DEPTH-1:0]        rom_data
`ifdef SPRITE_BLIT_MIRROR_EN
    ,
    input  logic                          mirror_x
`endif
);

    localparam int CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int CYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int XW  = DRAW_WIDTH_ADDRW + 1;
    localparam int YW  = DRAW_HEIGHT_ADDRW + 1;

    writer_state_t                  state;
    logic                           drain_cnt;
    logic [DRAW_WIDTH_ADDRW-1:0]    pos_x_lat;
    logic [DRAW_HEIGHT_ADDRW-1:0]   pos_y_lat;
    logic                           en_lat;
    logic                           mirror_lat;

    logic                           accept;
    logic                           sel_match;
    logic [CXW-1:0]                 cx;
    logic [CYW-1:0]                 cy;
    logic [CXW-1:0]                 cx_eff;
    logic                           last_pix;

    // Stage 1 travels alongside rom_addr, stage 2 alongside rom_data.
    logic                           s1_vld;
    logic [XW-1:0]                  s1_x;
    logic [YW-1:0]                  s1_y;
    logic                           s2_vld;
    logic [XW-1:0]                  s2_x;
    logic [YW-1:0]                  s2_y;

    assign sel_match = (wr.write_source_sel == SOURCE_SEL_ADDRW'(SOURCE_ID));
    assign accept    = (state == ST_IDLE) && wr.write_awaited && sel_match;
    assign cx_eff    = mirror_lat ? (CXW'(SPR_W - 1) - cx) : cx;

`ifndef SPRITE_BLIT_MIRROR_EN
    assign mirror_lat = 1'b0;
`endif

    sprite_sweep_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .CXW   (CXW),
        .CYW   (CYW)
    ) u_sweep (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .advance (state == ST_STREAM),
        .cx      (cx),
        .cy      (cy),
        .last    (last_pix)
    );

    // Writer FSM: accept and latch placement, sweep, drain the pipe, then wait for the request to clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
            pos_x_lat <= '0;
            pos_y_lat <= '0;
            en_lat    <= 1'b0;
`ifdef SPRITE_BLIT_MIRROR_EN
            mirror_lat <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_STREAM;
                        pos_x_lat <= pos_x;
                        pos_y_lat <= pos_y;
                        en_lat    <= sprite_en;
`ifdef SPRITE_BLIT_MIRROR_EN
                        mirror_lat <= mirror_x;
`endif
                    end
                end
                ST_STREAM: begin
                    if (last_pix) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state <= ST_RELEASE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!wr.write_awaited || !sel_match) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address/coordinate pipeline: counters -> rom_addr + screen coords -> align with rom_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            s1_vld   <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s2_vld   <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
        end else begin
            rom_addr <= AW'(cy) * AW'(SPR_W) + AW'(cx_eff);
            s1_vld   <= (state == ST_STREAM);
            s1_x     <= {1'b0, pos_x_lat} + XW'(cx);
            s1_y     <= {1'b0, pos_y_lat} + YW'(cy);
            s2_vld   <= s1_vld;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
        end
    end

    // Output register: key-colour, off-screen and disabled-sprite pixels go out transparent.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr.write_active      <= 1'b0;
            wr.write_transparent <= 1'b1;
            wr.write_color_data  <= '0;
            wr.write_x_addr      <= '0;
            wr.write_y_addr      <= '0;
        end else begin
            wr.write_active      <= s2_vld;
            wr.write_transparent <= !s2_vld
                                    || (rom_data == KEY_COLOR)
                                    || (s2_x >= XW'(DRAW_WIDTH))
                                    || (s2_y >= YW'(DRAW_HEIGHT))
                                    || !en_lat;
            if (s2_vld) begin
                wr.write_color_data <= rom_data;
                wr.write_x_addr     <= s2_x[DRAW_WIDTH_ADDRW-1:0];
                wr.write_y_addr     <= s2_y[DRAW_HEIGHT_ADDRW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sprite_blit_writer.sv
// Scoreboard bench for sprite_blit_writer with a 4x2 sprite and a behavioural 1-cycle ROM.
// Latency: checks start at accept+3 and an 8-cycle gapless burst.
// Backpressure: exercises source mismatch, stale write_awaited and mid-stream reset.
module tb_sprite_blit_writer;
    import sprite_blit_writer_pkg::*;

    localparam int SW   = 4;
    localparam int SH   = 2;
    localparam int SID  = 1;
    localparam int NPIX = SW * SH;
    localparam logic [7:0] KEY = 8'hE3;
`ifdef SPRITE_BLIT_MIRROR_EN
    localparam bit MIR = 1'b1;
`else
    localparam bit MIR = 1'b0;
`endif

    typedef struct packed {
        logic [DRAW_WIDTH_ADDRW-1:0]  x;
        logic [DRAW_HEIGHT_ADDRW-1:0] y;
        logic [COLOR_DEPTH-1:0]       c;
        logic                         t;
    } pix_t;

    logic                          clk = 1'b0;
    logic                          reset = 1'b1;
    logic                          sprite_en;
    logic [DRAW_WIDTH_ADDRW-1:0]   pos_x;
    logic [DRAW_HEIGHT_ADDRW-1:0]  pos_y;
    logic [2:0]                    rom_addr;
    logic [COLOR_DEPTH-1:0]        rom_data = '0;
    logic [COLOR_DEPTH-1:0]        rom_mem [NPIX];
`ifdef SPRITE_BLIT_MIRROR_EN
    logic                          mirror_x;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    pix_t exp_q[$];

    sprite_blit_writer_if wr();

    sprite_blit_writer #(
        .SOURCE_ID (SID),
        .SPR_W     (SW),
        .SPR_H     (SH),
        .KEY_COLOR (KEY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .sprite_en (sprite_en),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
`ifdef SPRITE_BLIT_MIRROR_EN
        ,
        .mirror_x  (mirror_x)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop one expected pixel per active output cycle.
    always @(negedge clk) begin
        pix_t got;
        pix_t e;
        if (wr.write_active) begin
            got = {wr.write_x_addr, wr.write_y_addr, wr.write_color_data, wr.write_transparent};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d c=%0d t=%0d, expected none",
                         got.x, got.y, got.c, got.t);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%0d t=%0d, expected x=%0d y=%0d c=%0d t=%0d",
                             got.x, got.y, got.c, got.t, e.x, e.y, e.c, e.t);
                end
            end
        end else begin
            chk("idle_transparent", int'(wr.write_transparent), 1);
        end
    end

    task automatic push_expected(input int px, input int py, input bit en, input bit mir, input int n);
        for (int i = 0; i < n; i++) begin
            int   cx;
            int   cy;
            int   xw;
            int   yw;
            pix_t e;
            cx  = i % SW;
            cy  = i / SW;
            xw  = px + cx;
            yw  = py + cy;
            e.c = rom_mem[cy * SW + (mir ? (SW - 1 - cx) : cx)];
            e.x = xw[DRAW_WIDTH_ADDRW-1:0];
            e.y = yw[DRAW_HEIGHT_ADDRW-1:0];
            e.t = (e.c == KEY) || (xw >= DRAW_WIDTH) || (yw >= DRAW_HEIGHT) || !en;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_sprite(input int px, input int py, input bit en, input bit mir, input int hold);
        int wait_c;
        int cnt;
        int stray;
        push_expected(px, py, en, mir, NPIX);
        pos_x     = DRAW_WIDTH_ADDRW'(px);
        pos_y     = DRAW_HEIGHT_ADDRW'(py);
        sprite_en = en;
`ifdef SPRITE_BLIT_MIRROR_EN
        mirror_x  = mir;
`endif
        wr.write_source_sel = SOURCE_SEL_ADDRW'(SID);
        wr.write_awaited    = 1'b1;
        @(negedge clk);
        // Inputs scrambled after accept must not disturb the running sweep.
        pos_x     = 10'd5;
        pos_y     = 9'd7;
        sprite_en = ~en;
`ifdef SPRITE_BLIT_MIRROR_EN
        mirror_x  = ~mir;
`endif
        wait_c = 0;
        while (!wr.write_active && wait_c < 10) begin
            @(negedge clk);
            wait_c++;
        end
        chk("start_latency", wait_c, 3);
        cnt = 0;
        while (wr.write_active && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("burst_len", cnt, NPIX);
        stray = 0;
        repeat (hold) begin
            @(negedge clk);
            if (wr.write_active) stray++;
        end
        chk("no_retrigger", stray, 0);
        wr.write_awaited = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        int wait_c;
        wr.write_awaited    = 1'b0;
        wr.write_source_sel = '0;
        pos_x     = '0;
        pos_y     = '0;
        sprite_en = 1'b0;
`ifdef SPRITE_BLIT_MIRROR_EN
        mirror_x  = 1'b0;
`endif
        for (int i = 0; i < NPIX; i++) rom_mem[i] = 8'(i);

        repeat (3) @(negedge clk);
        chk("rst_active",      int'(wr.write_active), 0);
        chk("rst_transparent", int'(wr.write_transparent), 1);
        chk("rst_color",       int'(wr.write_color_data), 0);
        chk("rst_x",           int'(wr.write_x_addr), 0);
        chk("rst_y",           int'(wr.write_y_addr), 0);
        chk("rst_rom_addr",    int'(rom_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic opaque sweep, with write_awaited held 10 extra cycles in RELEASE.
        run_sprite(10, 20, 1'b1, 1'b0, 10);

        // Key colour at ROM word 5 -> pixel (11,21) transparent.
        rom_mem[5] = KEY;
        run_sprite(10, 20, 1'b1, 1'b0, 0);
        rom_mem[5] = 8'd5;

        // Bottom-right corner clipping: only (638,479) and (639,479) opaque.
        run_sprite(638, 479, 1'b1, 1'b0, 0);

        // Disabled sprite still sweeps, all transparent.
        run_sprite(100, 100, 1'b0, 1'b0, 0);

        // Another source selected: nothing streams.
        wr.write_source_sel = SOURCE_SEL_ADDRW'(2);
        wr.write_awaited    = 1'b1;
        stray = 0;
        repeat (50) begin
            @(negedge clk);
            if (wr.write_active) stray++;
        end
        chk("sel_mismatch_quiet", stray, 0);
        run_sprite(200, 300, 1'b1, 1'b0, 0);

        // Mid-stream reset in the 3rd active cycle.
        push_expected(10, 20, 1'b1, 1'b0, 3);
        pos_x     = 10'd10;
        pos_y     = 9'd20;
        sprite_en = 1'b1;
`ifdef SPRITE_BLIT_MIRROR_EN
        mirror_x  = 1'b0;
`endif
        wr.write_source_sel = SOURCE_SEL_ADDRW'(SID);
        wr.write_awaited    = 1'b1;
        @(negedge clk);
        wait_c = 0;
        while (!wr.write_active && wait_c < 10) begin
            @(negedge clk);
            wait_c++;
        end
        chk("rst_test_start", wait_c, 3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wr.write_awaited = 1'b0;
        @(negedge clk);
        chk("rst_mid_active", int'(wr.write_active), 0);
        chk("rst_mid_popped", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_sprite(10, 20, 1'b1, MIR, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_blit_writer.md
Name: sprite_blit_writer

Overview:
- Write-side client of the double-buffered frame manager.
- When the manager signals that writes are awaited and selects this client's source ID, the block streams one rectangular sprite bitmap, pixel by pixel, into the back framebuffer.
- Bitmap pixels are fetched from an external synchronous ROM with 1-cycle read latency.
- Key-colour pixels and off-screen pixels are emitted as transparent, so the manager skips them.

Parameters:
- SOURCE_ID, 0, write-source index this instance answers to; compared against write_source_sel.
- SPR_W, 16, sprite width in pixels, 1..64.
- SPR_H, 16, sprite height in pixels, 1..64.
- KEY_COLOR, 8'hE3, ROM colour value treated as transparent.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- write_awaited  in  1  manager requests writes.
- write_source_sel  in  SOURCE_SEL_ADDRW  source currently selected by the manager.
- sprite_en  in  1  sprite visible this frame.
- pos_x  in  DRAW_WIDTH_ADDRW  top-left x; sampled at accept.
- pos_y  in  DRAW_HEIGHT_ADDRW  top-left y; sampled at accept.
- rom_addr  out  $clog2(SPR_W*SPR_H)  bitmap address, row-major.
- rom_data  in  COLOR_DEPTH  bitmap colour; valid 1 cycle after rom_addr.
- write_active  out  1  pixel stream valid.
- write_transparent  out  1  current pixel must not be stored.
- write_color_data  out  COLOR_DEPTH  current pixel colour.
- write_x_addr  out  DRAW_WIDTH_ADDRW  current pixel x.
- write_y_addr  out  DRAW_HEIGHT_ADDRW  current pixel y.

Behaviour:
- All outputs are registered.
- Reset values: write_active=0, write_transparent=1, write_color_data=0, write_x_addr=0, write_y_addr=0, rom_addr=0. Reset forces state IDLE.
- Reset mid-stream: write_active drops on the next edge and no further pixels are emitted.
- Accept condition: state IDLE && write_awaited && write_source_sel==SOURCE_ID. On accept, latch pos_x, pos_y and sprite_en; clear counters cx and cy.
- State machine:
  - IDLE -> STREAM on accept.
  - STREAM: advance cx each cycle, 0..SPR_W-1. On cx wrap, cx=0 and cy++. On the last pixel (cx=SPR_W-1, cy=SPR_H-1), go to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then go to RELEASE.
  - RELEASE: wait for ~write_awaited || write_source_sel!=SOURCE_ID, then go to IDLE. This prevents double triggering on a stale write_awaited.
- rom_addr = cy*SPR_W + cx, registered from the counters.
- Pipeline: counters -> rom_addr (1 cycle) -> rom_data (1 cycle) -> output register.
  - Pixel (0,0) is on the outputs 3 edges after the accept edge.
  - write_active stays high for exactly SPR_W*SPR_H consecutive cycles, with no gaps.
  - write_active falls the cycle after the last pixel.
- Coordinates: write_x_addr = pos_x + cx and write_y_addr = pos_y + cy, computed 1 bit wider.
- Transparency: write_transparent = (rom_data==KEY_COLOR) || x_wide>=DRAW_WIDTH || y_wide>=DRAW_HEIGHT || ~sprite_en_latched.
  - For clipped pixels, the address outputs carry the truncated value, which the manager ignores.
- sprite_en=0 at accept: the full sweep still runs with all pixels transparent. This keeps the manager handshake intact.
- Changes on pos_x, pos_y or sprite_en after accept have no effect until the next accept.
- While write_active=0, write_transparent=1.

Optional Feature:
- Macro: SPRITE_BLIT_MIRROR_EN.
- Defined: extra input port mirror_x (1 bit), latched at accept. When the latched value is 1, rom_addr uses (SPR_W-1-cx) in place of cx; the screen x stays pos_x+cx. Latency and timing are unchanged.
- Undefined: no mirror_x port; no mirroring.

Decomposition:
- The shared package holds DRAW_WIDTH, DRAW_HEIGHT, DRAW_WIDTH_ADDRW, DRAW_HEIGHT_ADDRW, COLOR_DEPTH and SOURCE_SEL_ADDRW, taken from the frame-manager definitions, plus the writer state enum typedef.
- One natural sub-module: sprite_sweep_counter, holding cx/cy, the wrap logic and the last-pixel flag.

Test Plan:
- SPR_W=4, SPR_H=2, pos=(10,20), ROM=0..7, KEY_COLOR=8'hE3, write_awaited=1, sel=SOURCE_ID -> write_active high 8 cycles starting at accept+3; (x,y,colour) = (10,20,0)…(13,21,7); write_transparent=0 throughout.
- ROM word 5 = 8'hE3 -> pixel (11,21) has write_transparent=1; all other pixels stay opaque.
- pos=(638,479), 4x2 sprite -> only (638,479) and (639,479) are opaque; the other 6 pixels are transparent.
- write_awaited=1 but sel!=SOURCE_ID for 50 cycles -> write_active stays 0; once sel matches, the stream starts 3 cycles later.
- After the stream, write_awaited is held at 1 for 10 extra cycles -> no second stream; the block stays in RELEASE until write_awaited falls.
- Assert reset in the 3rd active cycle -> write_active=0 on the next edge; after release, a new accept streams the full 8 pixels correctly (with SPRITE_BLIT_MIRROR_EN and mirror_x=1, row 0 colours are 3,2,1,0).
